// File: rtl/uart_packet_sender_pkg.sv
// Shared types and constants for the framed telemetry UART transmitter.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Sync byte, timestamp bytes, flag byte, checksum byte.
    function automatic int n_bytes(input int time_w);
        return time_w / 8 + 3;
    endfunction

endpackage

// File: rtl/uart_packet_sender_byte_tx.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       send,
    output logic       tx,
    output logic       ready
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              active_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [3:0]        bit_cnt_reg;
    logic [9:0]        shift_reg;
    logic              last_tick;

    assign last_tick = (baud_cnt_reg == BAUD_LAST);
    // Ready already on the final stop-bit cycle so a following byte can be
    // accepted without an extra idle bit.
    assign ready = !active_reg || (last_tick && bit_cnt_reg == 4'd9);
    assign tx    = shift_reg[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_reg   <= 1'b0;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '1;
        end else if (ready && send) begin
            active_reg   <= 1'b1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= {1'b1, data, 1'b0};
        end else if (active_reg) begin
            if (last_tick) begin
                baud_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd9) begin
                    active_reg <= 1'b0;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    shift_reg   <= {1'b1, shift_reg[9:1]};
                end
            end else begin
                baud_cnt_reg <= baud_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_packet_sender.sv
// Event-triggered telemetry packet sender: snapshots timestamp and channel
// flags and sends them as a sync-framed, XOR-checksummed UART packet.
module uart_packet_sender
    import uart_pkt_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         TIME_W       = 32,
    parameter int         NUM_CH       = 4,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [TIME_W-1:0] time_value,
    input  logic [NUM_CH-1:0] ch_in,
    input  logic              mode,
    input  logic              start,
    output logic              tx,
    output logic              busy,
    output logic              pkt_done,
    output logic              overrun
);
    localparam int N_BYTES    = n_bytes(TIME_W);
    localparam int TIME_BYTES = TIME_W / 8;
    localparam int IDX_W      = $clog2(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [IDX_W-1:0] FLAG_IDX = IDX_W'(TIME_BYTES + 1);

    state_t            state_reg, state_next;
    logic [NUM_CH-1:0] ch_meta_reg, ch_s_reg, ch_d_reg;
    logic [TIME_W-1:0] snap_time_reg;
    logic [NUM_CH-1:0] snap_ch_reg;
    logic [IDX_W-1:0]  byte_idx_reg;
    logic [7:0]        csum_reg;
    logic [7:0]        byte_reg;
    logic              overrun_reg;
    logic              trig;
    logic              ser_send;
    logic              ser_ready;
    logic [7:0]        sel_byte;
    logic [7:0]        flag_byte;
    logic [7:0]        time_bytes [TIME_BYTES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_meta_reg <= '0;
            ch_s_reg    <= '0;
            ch_d_reg    <= '0;
        end else begin
            ch_meta_reg <= ch_in;
            ch_s_reg    <= ch_meta_reg;
            ch_d_reg    <= ch_s_reg;
        end
    end

    assign trig = mode ? (ch_s_reg != ch_d_reg) : start;

    // Timestamp bytes, most significant first.
    generate
        for (genvar gi = 0; gi < TIME_BYTES; gi++) begin : g_time_byte
            assign time_bytes[gi] = snap_time_reg[TIME_W-1-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        flag_byte = '0;
        flag_byte[NUM_CH-1:0] = snap_ch_reg;
        sel_byte = csum_reg;
        if (byte_idx_reg == '0) begin
            sel_byte = SYNC_BYTE;
        end else if (byte_idx_reg == FLAG_IDX) begin
            sel_byte = flag_byte;
        end
        for (int i = 0; i < TIME_BYTES; i++) begin
            if (byte_idx_reg == IDX_W'(i + 1)) sel_byte = time_bytes[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (trig) state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    if (ser_ready) state_next = WAIT;
            WAIT:    if (ser_ready) state_next = (byte_idx_reg < LAST_IDX) ? LOAD : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        pkt_done = (state_reg == DONE);
        ser_send = (state_reg == SEND);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_time_reg <= '0;
            snap_ch_reg   <= '0;
            byte_idx_reg  <= '0;
            csum_reg      <= '0;
            byte_reg      <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            // DONE counts as busy, so a trigger there is dropped too.
            overrun_reg <= trig && (state_reg != IDLE);
            unique case (state_reg)
                IDLE: begin
                    if (trig) begin
                        snap_time_reg <= time_value;
                        snap_ch_reg   <= ch_s_reg;
                        byte_idx_reg  <= '0;
                        csum_reg      <= '0;
                    end
                end
                LOAD: begin
                    byte_reg <= sel_byte;
                    csum_reg <= csum_reg ^ sel_byte;
                end
                WAIT: begin
                    if (ser_ready && byte_idx_reg < LAST_IDX) byte_idx_reg <= byte_idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign overrun = overrun_reg;

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (byte_reg),
        .send    (ser_send),
        .tx      (tx),
        .ready   (ser_ready)
    );

endmodule

// File: tb/tb_uart_packet_sender.sv
// Directed bench for uart_packet_sender: decodes the UART line and compares
// packets, pulses and timing against hand-computed values.
module tb_uart_packet_sender;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] time_value = '0;
    logic [3:0]  ch_in = '0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic        tx, busy, pkt_done, overrun;

    int checks = 0;
    int passed = 0;

    byte unsigned rx_q[$];
    int           done_cnt, ovr_cnt, busy_cnt, frame_err;
    int           rx_cnt;
    logic         rx_active = 1'b0;
    logic [7:0]   rx_sh = '0;

    // A5 ^ 12 ^ 34 ^ 56 ^ 78 ^ 05 = A8 ; A5 ^ 00 ^ 00 ^ 01 ^ 00 ^ 08 = AC
    byte unsigned pkt_a [7] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h05, 8'hA8};
    byte unsigned pkt_b [7] = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h08, 8'hAC};

    uart_packet_sender #(
        .CLKS_PER_BIT (CPB),
        .TIME_W       (32),
        .NUM_CH       (4),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .time_value (time_value),
        .ch_in      (ch_in),
        .mode       (mode),
        .start      (start),
        .tx         (tx),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
            $display("check %s: got %0h expected %0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line decoder and pulse counters, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (pkt_done === 1'b1) done_cnt++;
            if (overrun === 1'b1) ovr_cnt++;
            if (busy === 1'b1) busy_cnt++;
            if (!reset_n) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt > CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == 1)
                    rx_sh = {tx, rx_sh[7:1]};
                if (rx_cnt == 9 * CPB + 1) begin
                    if (tx === 1'b1) rx_q.push_back(rx_sh);
                    else frame_err++;
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic clear_mon();
        @(posedge clk);
        rx_q.delete();
        done_cnt = 0;
        ovr_cnt = 0;
        busy_cnt = 0;
        frame_err = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (pkt_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic check_pkt(input string tag, input byte unsigned exp [7], input int base);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("%s_b%0d", tag, i),
                  (base + i < rx_q.size()) ? {24'b0, rx_q[base + i]} : 32'hFFFF_FFFF,
                  {24'b0, exp[i]});
        end
    endtask

    initial begin
        int n;
        int bad;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_200_bad_cycles", 32'(bad), 32'd0);

        // Single packet, timestamp changed right after capture.
        time_value = 32'h1234_5678;
        ch_in = 4'b0101;
        repeat (5) @(negedge clk);
        clear_mon();
        pulse_start();
        time_value = 32'hDEAD_BEEF;
        n = 0;
        while (tx !== 1'b0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("a_start_latency_ok", 32'(n <= 3), 32'd1);
        wait_done("a_done_seen");
        repeat (60) @(negedge clk);
        check("a_nbytes", 32'(rx_q.size()), 32'd7);
        check_pkt("a", pkt_a, 0);
        check("a_done_cnt", 32'(done_cnt), 32'd1);
        check("a_ovr_cnt", 32'(ovr_cnt), 32'd0);
        check("a_busy_len_ok", 32'((busy_cnt >= 280) && (busy_cnt <= 301)), 32'd1);
        check("a_frame_err", 32'(frame_err), 32'd0);

        // Auto mode: one change triggers, a mid-packet change overruns.
        time_value = 32'h0000_0100;
        ch_in = 4'b0000;
        repeat (5) @(negedge clk);
        mode = 1'b1;
        repeat (3) @(negedge clk);
        clear_mon();
        @(negedge clk);
        ch_in = 4'b1000;
        repeat (60) @(negedge clk);
        ch_in = 4'b0000;
        wait_done("b_done_seen");
        repeat (200) @(negedge clk);
        check("b_nbytes", 32'(rx_q.size()), 32'd7);
        check_pkt("b", pkt_b, 0);
        check("b_done_cnt", 32'(done_cnt), 32'd1);
        check("b_ovr_cnt", 32'(ovr_cnt), 32'd1);
        mode = 1'b0;

        // Reset during the third byte, then a clean packet.
        time_value = 32'h1234_5678;
        ch_in = 4'b0101;
        repeat (5) @(negedge clk);
        clear_mon();
        pulse_start();
        n = 0;
        while (rx_q.size() < 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        n = 0;
        while (tx !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("c_line_low_before_reset", 32'(tx), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("c_rst_tx", 32'(tx), 32'd1);
        check("c_rst_busy", 32'(busy), 32'd0);
        check("c_rst_pkt_done", 32'(pkt_done), 32'd0);
        check("c_rst_overrun", 32'(overrun), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        clear_mon();
        pulse_start();
        wait_done("c_done_seen");
        repeat (60) @(negedge clk);
        check("c_nbytes", 32'(rx_q.size()), 32'd7);
        check_pkt("c", pkt_a, 0);

        // Start during DONE is dropped as overrun.
        clear_mon();
        pulse_start();
        wait_done("d_done_seen");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        check("d_nbytes", 32'(rx_q.size()), 32'd7);
        check("d_done_cnt", 32'(done_cnt), 32'd1);
        check("d_ovr_cnt", 32'(ovr_cnt), 32'd1);

        // Start one clock after pkt_done is accepted.
        clear_mon();
        pulse_start();
        wait_done("e_done1_seen");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("e_done2_seen");
        repeat (60) @(negedge clk);
        check("e_nbytes", 32'(rx_q.size()), 32'd14);
        check_pkt("e1", pkt_a, 0);
        check_pkt("e2", pkt_a, 7);
        check("e_done_cnt", 32'(done_cnt), 32'd2);
        check("e_ovr_cnt", 32'(ovr_cnt), 32'd0);
        check("e_frame_err", 32'(frame_err), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
